data_sram_responder: RTL

DATA_SRAM_RESPONDER -- requirements
Module: data_sram_responder

---
 rtl/data_sram_responder.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/data_sram_responder.sv
// data_sram_responder
//   Behavioural SRAM slave for a req/addr_ok/data_ok style data port.
//   Accepted requests are answered strictly in order, each exactly LATENCY
//   cycles after acceptance. At most QDEPTH requests can be outstanding.
//
// Parameters
//   DEPTH_LOG2 : memory holds 2**DEPTH_LOG2 32-bit words (must be <= 29)
//   LATENCY    : cycles from acceptance to data_ok, 1..7
//   QDEPTH     : maximum outstanding requests, power of 2
//
// Ports
//   clk               rising-edge clock
//   resetn            asynchronous active-low reset
//   data_sram_req     request valid
//   data_sram_wr      1 = write, 0 = read
//   data_sram_size    access size (informational only, not used)
//   data_sram_wstrb   byte write enables (writes only)
//   data_sram_addr    byte address, word index = addr[DEPTH_LOG2+1:2]
//   data_sram_wdata   write data
//   data_sram_addr_ok request accepted this cycle
//   data_sram_data_ok response for the oldest outstanding request
//   data_sram_rdata   read data while data_ok is high, otherwise 0
//   stall             forces addr_ok low

module data_sram_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2,
  parameter int QDEPTH     = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  input  logic        stall
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam int WORDS = 2 ** DEPTH_LOG2;

  localparam logic [CNT_W-1:0] QDEPTH_C = CNT_W'(QDEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(QDEPTH - 1);
  localparam logic [2:0]       LAT_INIT = 3'(LATENCY - 1);

  generate
    if (LATENCY < 1 || LATENCY > 7) begin : g_bad_latency
      $error("data_sram_responder: LATENCY must be 1..7");
    end
    if (QDEPTH < 1 || (QDEPTH & (QDEPTH - 1)) != 0) begin : g_bad_qdepth
      $error("data_sram_responder: QDEPTH must be a power of 2");
    end
  endgenerate

  logic [31:0] mem [WORDS];

  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  handshake;
  logic                  pop;

  logic                  q_is_read [QDEPTH];
  logic [31:0]           q_data    [QDEPTH];
  logic [2:0]            q_cnt     [QDEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;

  // Size and the address bits outside the word index play no role.
  logic unused_bits;
  assign unused_bits = ^{data_sram_size,
                         data_sram_addr[31:DEPTH_LOG2+2],
                         data_sram_addr[1:0]};

  assign word_idx = data_sram_addr[DEPTH_LOG2+1:2];

  // No bypass when full: a pop in this cycle does not free a slot until the
  // next cycle. resetn is folded in so addr_ok is low throughout reset.
  assign data_sram_addr_ok = resetn & data_sram_req & ~stall & (count < QDEPTH_C);
  assign handshake         = data_sram_addr_ok;

  // count is cleared asynchronously, which also forces pop low during reset.
  assign pop               = (count != '0) && (q_cnt[rd_ptr] == 3'd0);
  assign data_sram_data_ok = pop;
  assign data_sram_rdata   = (pop && q_is_read[rd_ptr]) ? q_data[rd_ptr] : 32'h0;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Memory array is deliberately not reset; contents survive resetn.
  always_ff @(posedge clk) begin
    if (handshake && data_sram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wstrb[i]) begin
          mem[word_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  // Response queue. Every entry ages each cycle; the head is released as
  // soon as its counter has reached zero. A freshly pushed entry overrides
  // the aging of its (empty) slot.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_is_read[i] <= 1'b0;
        q_data[i]    <= 32'h0;
        q_cnt[i]     <= 3'd0;
      end
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (q_cnt[i] != 3'd0) begin
          q_cnt[i] <= q_cnt[i] - 3'd1;
        end
      end

      if (handshake) begin
        q_cnt[wr_ptr]     <= LAT_INIT;
        q_is_read[wr_ptr] <= ~data_sram_wr;
        // Reads capture the word as it stands before this edge; only one
        // handshake per cycle, so no same-edge write can alias it.
        q_data[wr_ptr]    <= data_sram_wr ? 32'h0 : mem[word_idx];
        wr_ptr            <= ptr_next(wr_ptr);
      end

      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end

      case ({handshake, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
